// File: rtl/gate_share_arbiter.sv
// Round-robin sequencer sharing one registered 2-input AND unit among N_REQ requesters.
// Accepts one operand at a time and returns the result under a valid/ready handshake.
module gate_share_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [2*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_resp_valid,
    output logic                 o_resp_data,
    input  logic                 i_resp_ready,
    output logic                 o_busy,
    output logic [15:0]          o_done_count
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_win;
    logic [1:0]         r_op;
    logic               r_result;
    logic [N_REQ-1:0]   r_resp_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_done_count;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [1:0]         w_op;

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!w_found && i_req_valid[IDX_W'((32'(r_last) + i) % N_REQ)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((32'(r_last) + i) % N_REQ);
            end
        end
        w_op = 2'(i_req_data >> {w_win, 1'b0});
    end

    // Grant is combinational and suppressed while reset is held.
    assign o_req_ready = (r_state == S_IDLE && w_found && !i_rst) ? (ONE << w_win) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_last       <= IDX_W'(N_REQ - 1);
            r_win        <= '0;
            r_op         <= '0;
            r_result     <= 1'b0;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op    <= w_op;
                        r_win   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_result     <= r_op[0] & r_op[1];
                    r_resp_valid <= ONE << r_win;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_last       <= r_win;
                        r_done_count <= r_done_count + CNT_W'(1);
                        r_resp_valid <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_result;
    assign o_busy       = r_busy;
    assign o_done_count = r_done_count;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Scoreboard bench for gate_share_arbiter: directed requests push expected responses,
// a monitor pops and compares them on every response handshake.
module tb_gate_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_data;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic        resp_data;
    logic        resp_ready;
    logic        busy;
    logic [15:0] done_count;

    typedef struct {
        logic [3:0]  valid;
        logic        data;
        logic [15:0] done;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cyc;
    logic [15:0] exp_done = '0;
    bit          ok;

    gate_share_arbiter #(.N_REQ(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .i_resp_ready (resp_ready),
        .o_busy       (busy),
        .o_done_count (done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic res);
        exp_t e;
        e.valid  = 4'b0001 << k;
        e.data   = res;
        e.done   = exp_done;
        exp_done = exp_done + 16'd1;
        q.push_back(e);
    endtask

    task automatic wait_grant(input int k, output bit found);
        logic [3:0] want;
        want  = 4'b0001 << k;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                chk("grant", 32'(req_ready), 32'(want));
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout requester=%0d actual=none expected=%b", k, want);
        end
    endtask

    // One full transaction with resp_ready high: grant in cycle 0, handshake in cycle 2.
    task automatic do_xact(input int k, input logic [3:0] vmask, input logic [7:0] data, input logic res);
        @(posedge clk); #1;
        req_valid = vmask;
        req_data  = data;
        push(k, res);
        wait_grant(k, ok);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && resp_valid != 4'b0000) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%b expected=none", resp_valid);
                end else if (resp_ready) begin
                    mon_e = q.pop_front();
                    chk("resp_valid", 32'(resp_valid), 32'(mon_e.valid));
                    chk("resp_data", 32'(resp_data), 32'(mon_e.data));
                    chk("done_at_handshake", 32'(done_count), 32'(mon_e.done));
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int          ord[6];
        logic [5:0]  fres;
        ord  = '{0, 1, 2, 3, 0, 1};
        fres = 6'b010101;

        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_data   = 8'hFF;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done_count), 32'h0);
        chk("reset_resp_data", 32'(resp_data), 32'h0);
        @(posedge clk); #1;
        rst        = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;

        // Single request, checked cycle by cycle.
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_data  = 8'b0000_0011;
        push(0, 1'b1);
        wait_grant(0, ok);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("eval_busy", 32'(busy), 32'h1);
        chk("eval_resp_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("resp_cycle2_valid", 32'(resp_valid), 32'h1);
        @(negedge clk);
        chk("single_done", 32'(done_count), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);

        // Truth table through requester 2.
        do_xact(2, 4'b0100, 8'b0000_0000, 1'b0);
        do_xact(2, 4'b0100, 8'b0001_0000, 1'b0);
        do_xact(2, 4'b0100, 8'b0010_0000, 1'b0);
        do_xact(2, 4'b0100, 8'b0011_0000, 1'b1);
        @(negedge clk);
        chk("truth_done", 32'(done_count), 32'd5);

        // Fairness from a fresh reset: grants 0,1,2,3,0,1 spaced 3 cycles.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_done = '0;
        req_data  = 8'b10_11_01_11;
        req_valid = 4'b1111;
        last_cyc  = 0;
        for (int g = 0; g < 6; g++) begin
            push(ord[g], fres[g]);
            wait_grant(ord[g], ok);
            if (g > 0) chk("grant_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("fair_done", 32'(done_count), 32'd6);

        // Backpressure: RESP held 5 cycles with all requesters pending.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        push(2, 1'b1);
        wait_grant(2, ok);
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'b0100);
            chk("bp_resp_data", 32'(resp_data), 32'h1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_done", 32'(done_count), 32'd6);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_valid  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("bp_done_after", 32'(done_count), 32'd7);
        chk("bp_busy_after", 32'(busy), 32'h0);

        // Reset during EVAL discards the transaction.
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_data  = 8'b0000_1100;
        wait_grant(1, ok);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_done", 32'(done_count), 32'h0);
        chk("midrst_resp_data", 32'(resp_data), 32'h0);
        exp_done = '0;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        req_data  = 8'b10_11_01_11;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 1'b1);
        wait_grant(0, ok);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("postrst_done", 32'(done_count), 32'h1);

        // Counter wrap: preload near the top, then two handshakes.
        @(posedge clk); #1;
        force dut.r_done_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_done_count;
        exp_done = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", 32'(done_count), 32'hFFFE);
        do_xact(3, 4'b1000, 8'b10_00_00_00, 1'b0);
        @(negedge clk);
        chk("wrap_ffff", 32'(done_count), 32'hFFFF);
        do_xact(0, 4'b0001, 8'b00_00_00_11, 1'b1);
        @(negedge clk);
        chk("wrap_zero", 32'(done_count), 32'h0000);

        @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
